// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared constants and types for the data-memory arbiter
// Purpose: access-width encodings, FSM state values, port indices and the
//          width-independent part of a captured request.
// Ports:   none (package).
package dmem_arbiter_pkg;

   // Access width encodings on pN_width / mem_width
   localparam logic [1:0] W64 = 2'd0;
   localparam logic [1:0] W32 = 2'd1;
   localparam logic [1:0] W16 = 2'd2;
   localparam logic [1:0] W8  = 2'd3;

   // Arbiter FSM states
   localparam logic IDLE = 1'b0;
   localparam logic WAIT = 1'b1;

   // Requester indices
   localparam int PORT_EX = 0;   // execute memory unit
   localparam int PORT_IF = 1;   // instruction fetch / refill

   typedef struct packed {
      logic [63:0] dout;
      logic [1:0]  width;
      logic        is_write;
   } req_payload_t;

   function automatic logic [3:0] width_bytes(input logic [1:0] width);
      case (width)
         W64:     width_bytes = 4'd8;
         W32:     width_bytes = 4'd4;
         W16:     width_bytes = 4'd2;
         W8:      width_bytes = 4'd1;
         default: width_bytes = 4'd1;
      endcase
   endfunction

endpackage

// File: rtl/dmem_req_slot.sv
// rtl/dmem_req_slot.sv - one-entry pending request slot for one arbiter port
// Purpose: captures a single-cycle read/write strobe into a held request and
//          flags overruns (both strobes together, or a strobe while pending).
// Ports:   clk, rst_n             clock, synchronous active-low reset
//          addr, dout, width      request fields sampled on a strobe
//          rstrobe, wstrobe       one-cycle request pulses
//          clear                  arbiter finished this port's transaction
//          pending                slot holds an unserved/in-flight request
//          slot_addr, slot_req    held request
//          overrun                combinational overrun indication this cycle
module dmem_req_slot
   import dmem_arbiter_pkg::*;
#(
   parameter int ADDR_W = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] addr,
   input  logic [63:0]       dout,
   input  logic [1:0]        width,
   input  logic              rstrobe,
   input  logic              wstrobe,
   input  logic              clear,
   output logic              pending,
   output logic [ADDR_W-1:0] slot_addr,
   output req_payload_t      slot_req,
   output logic              overrun
);

   logic strobe;

   assign strobe  = rstrobe | wstrobe;
   // A strobe on the completion edge still sees pending set, so it is dropped.
   assign overrun = (strobe & pending) | (rstrobe & wstrobe);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pending   <= 1'b0;
         slot_addr <= '0;
         slot_req  <= '{dout: 64'd0, width: W64, is_write: 1'b0};
      end else if (clear) begin
         pending <= 1'b0;
      end else if (strobe && !pending) begin
         pending           <= 1'b1;
         slot_addr         <= addr;
         slot_req.dout     <= dout;
         slot_req.width    <= width;
         slot_req.is_write <= wstrobe;   // both strobes together count as a write
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port strobe-protocol arbiter for the data-memory bus
// Purpose: port 0 (execute) and port 1 (fetch) share one memory bus; requests
//          are held in per-port slots, granted one at a time, completions and
//          read data are routed back, and a watchdog forces completion.
// Config:  DMEM_ARB_ROUND_ROBIN_EN - ties go to the port not granted last;
//          undefined: port 0 always wins a tie.
// Ports:   clk, rst_n                          clock, synchronous active-low reset
//          pN_addr/dout/width/rstrobe/wstrobe  port requests (N = 0, 1)
//          pN_din, pN_cycle_complete           port read data and done pulse
//          mem_addr/dout/width/rstrobe/wstrobe bus request
//          mem_din, mem_cycle_complete         bus read data and done pulse
//          grant, busy                         current/last owner, state != IDLE
//          err_overrun, err_timeout            sticky error flags
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int ADDR_W         = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [63:0]       p0_dout,
   input  logic [1:0]        p0_width,
   input  logic              p0_rstrobe,
   input  logic              p0_wstrobe,
   output logic [63:0]       p0_din,
   output logic              p0_cycle_complete,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [63:0]       p1_dout,
   input  logic [1:0]        p1_width,
   input  logic              p1_rstrobe,
   input  logic              p1_wstrobe,
   output logic [63:0]       p1_din,
   output logic              p1_cycle_complete,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [63:0]       mem_dout,
   output logic [1:0]        mem_width,
   output logic              mem_rstrobe,
   output logic              mem_wstrobe,
   input  logic [63:0]       mem_din,
   input  logic              mem_cycle_complete,
   output logic              grant,
   output logic              busy,
   output logic              err_overrun,
   output logic              err_timeout
);

   localparam bit          WDOG_EN = (TIMEOUT_CYCLES != 0);
   // Counter starts at 0 on the grant edge; the timeout edge is when it would reach TIMEOUT_CYCLES.
   localparam logic [31:0] TO_LAST = (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);

   logic [1:0]        pend;
   logic [1:0]        ovr;
   logic [1:0]        clr;
   logic [ADDR_W-1:0] slot_addr [2];
   req_payload_t      slot_req  [2];
   logic              state_q, state_d;
   logic              issue, fin_ok, fin_to;
   logic              win;
   logic              timeout_hit;
   logic [31:0]       wd_cnt;
   logic [1:0]        cc_q;
   logic [63:0]       din_q [2];

   dmem_req_slot #(.ADDR_W(ADDR_W)) u_slot_ex (
      .clk(clk), .rst_n(rst_n),
      .addr(p0_addr), .dout(p0_dout), .width(p0_width),
      .rstrobe(p0_rstrobe), .wstrobe(p0_wstrobe), .clear(clr[PORT_EX]),
      .pending(pend[PORT_EX]), .slot_addr(slot_addr[PORT_EX]),
      .slot_req(slot_req[PORT_EX]), .overrun(ovr[PORT_EX])
   );

   dmem_req_slot #(.ADDR_W(ADDR_W)) u_slot_if (
      .clk(clk), .rst_n(rst_n),
      .addr(p1_addr), .dout(p1_dout), .width(p1_width),
      .rstrobe(p1_rstrobe), .wstrobe(p1_wstrobe), .clear(clr[PORT_IF]),
      .pending(pend[PORT_IF]), .slot_addr(slot_addr[PORT_IF]),
      .slot_req(slot_req[PORT_IF]), .overrun(ovr[PORT_IF])
   );

`ifdef DMEM_ARB_ROUND_ROBIN_EN
   logic last_grant;

   always_comb begin
      win = pend[PORT_EX] ? 1'b0 : 1'b1;
      if (&pend) win = ~last_grant;
   end

   // Resets to port 1 so port 0 takes the first tie.
   always_ff @(posedge clk) begin
      if (!rst_n)     last_grant <= 1'b1;
      else if (issue) last_grant <= win;
   end
`else
   always_comb win = pend[PORT_EX] ? 1'b0 : 1'b1;
`endif

   assign timeout_hit = WDOG_EN && (wd_cnt == TO_LAST);
   assign busy        = (state_q == WAIT);
   assign p0_din            = din_q[PORT_EX];
   assign p1_din            = din_q[PORT_IF];
   assign p0_cycle_complete = cc_q[PORT_EX];
   assign p1_cycle_complete = cc_q[PORT_IF];

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (|pend) state_d = WAIT;
         WAIT:    if (mem_cycle_complete || timeout_hit) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // A bus completion on the timeout edge wins over the watchdog.
   always_comb begin
      issue  = 1'b0;
      fin_ok = 1'b0;
      fin_to = 1'b0;
      clr    = 2'b00;
      case (state_q)
         IDLE: issue = |pend;
         WAIT: begin
            fin_ok     = mem_cycle_complete;
            fin_to     = !mem_cycle_complete && timeout_hit;
            clr[grant] = mem_cycle_complete || timeout_hit;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mem_addr    <= '0;
         mem_dout    <= '0;
         mem_width   <= W64;
         mem_rstrobe <= 1'b0;
         mem_wstrobe <= 1'b0;
         grant       <= 1'b0;
         wd_cnt      <= '0;
         cc_q        <= 2'b00;
         din_q[0]    <= '0;
         din_q[1]    <= '0;
         err_overrun <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         mem_rstrobe <= 1'b0;
         mem_wstrobe <= 1'b0;
         cc_q        <= 2'b00;
         if (|ovr) err_overrun <= 1'b1;
         if (issue) begin
            mem_addr    <= slot_addr[win];
            mem_dout    <= slot_req[win].dout;
            mem_width   <= slot_req[win].width;
            mem_rstrobe <= !slot_req[win].is_write;
            mem_wstrobe <= slot_req[win].is_write;
            grant       <= win;
            wd_cnt      <= '0;
         end
         if (fin_ok) begin
            cc_q[grant] <= 1'b1;
            if (!slot_req[grant].is_write) din_q[grant] <= mem_din;
         end else if (fin_to) begin
            cc_q[grant] <= 1'b1;
            if (!slot_req[grant].is_write) din_q[grant] <= '0;
            err_timeout <= 1'b1;
         end else if (busy && WDOG_EN) begin
            wd_cnt <= wd_cnt + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

   localparam int TO = 4;
   localparam logic [63:0] D1 = 64'hDEADBEEF_CAFEF00D;
   localparam logic [63:0] D2 = 64'h1111_2222_3333_4444;
   localparam logic [63:0] D3 = 64'h0123_4567_89AB_CDEF;
   localparam logic [63:0] A0 = 64'h1000;
   localparam logic [63:0] A1 = 64'h2000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [63:0] p0_addr, p0_dout, p0_din, p1_addr, p1_dout, p1_din;
   logic [1:0]  p0_width, p1_width, mem_width;
   logic        p0_rstrobe, p0_wstrobe, p0_cycle_complete;
   logic        p1_rstrobe, p1_wstrobe, p1_cycle_complete;
   logic [63:0] mem_addr, mem_dout, mem_din;
   logic        mem_rstrobe, mem_wstrobe, mem_cycle_complete;
   logic        grant, busy, err_overrun, err_timeout;

   always #5 clk = ~clk;

   dmem_arbiter #(.TIMEOUT_CYCLES(TO), .ADDR_W(64)) dut (
      .clk(clk), .rst_n(rst_n),
      .p0_addr(p0_addr), .p0_dout(p0_dout), .p0_width(p0_width),
      .p0_rstrobe(p0_rstrobe), .p0_wstrobe(p0_wstrobe),
      .p0_din(p0_din), .p0_cycle_complete(p0_cycle_complete),
      .p1_addr(p1_addr), .p1_dout(p1_dout), .p1_width(p1_width),
      .p1_rstrobe(p1_rstrobe), .p1_wstrobe(p1_wstrobe),
      .p1_din(p1_din), .p1_cycle_complete(p1_cycle_complete),
      .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_width(mem_width),
      .mem_rstrobe(mem_rstrobe), .mem_wstrobe(mem_wstrobe),
      .mem_din(mem_din), .mem_cycle_complete(mem_cycle_complete),
      .grant(grant), .busy(busy),
      .err_overrun(err_overrun), .err_timeout(err_timeout)
   );

   typedef struct {
      bit p0r, p0w, p1r, p1w, mcc;
      logic [63:0] mdin;
      bit mr, mw, bsy, gnt, cc0, cc1;
      logic [63:0] din0, din1, maddr;
   } vec_t;

   typedef struct {
      logic [63:0] addr;
      logic [63:0] dout;
      logic [1:0]  w;
      logic        wr;
      int          cap;
   } req_t;

   vec_t tbl [12];
   int   n_vec = 0;
   int   n_bad = 0;
   int   cyc   = 0;

   // Random-phase model state
   req_t        rq [2];
   bit          wt [2];
   bit          os [2];
   logic [63:0] edin [2];
   logic [1:0]  ecc;
   logic [63:0] e_addr, e_dout, rdat;
   logic [1:0]  e_w;
   logic        e_mr, e_mw, egnt, eovr, eto, to_f;
   int          owner, done_e, mem_rem, lastg;

   int n_str, n_cc0, n_cc1, t_str, t_cc;
   logic acc;

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      p0_rstrobe = 0; p0_wstrobe = 0; p1_rstrobe = 0; p1_wstrobe = 0;
      mem_cycle_complete = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 0;
      step();
      rst_n = 1;
   endtask

   // Acts as the memory with a fixed latency (0 = never answers) for ncyc cycles.
   task automatic run_mem(input int lat, input logic [63:0] data, input int ncyc,
                          output int ns, output int nc0, output int nc1,
                          output int ts, output int tc);
      int rem = 0;
      ns = 0; nc0 = 0; nc1 = 0; ts = -1; tc = -1;
      for (int i = 0; i < ncyc; i++) begin
         step();
         p0_rstrobe = 0; p0_wstrobe = 0; p1_rstrobe = 0; p1_wstrobe = 0;
         if (mem_rstrobe || mem_wstrobe) begin
            ns++;
            if (ts < 0) ts = i;
            rem = lat;
         end
         if (p0_cycle_complete) begin nc0++; tc = i; end
         if (p1_cycle_complete) begin nc1++; tc = i; end
         mem_cycle_complete = (rem == 1);
         mem_din = data;
         if (rem > 0) rem--;
      end
      mem_cycle_complete = 0;
   endtask

   task automatic drive_port(input int p, input logic r, input logic w,
                             input logic [63:0] a, input logic [63:0] d, input logic [1:0] wd);
      if (p == 0) begin
         p0_rstrobe = r; p0_wstrobe = w; p0_addr = a; p0_dout = d; p0_width = wd;
      end else begin
         p1_rstrobe = r; p1_wstrobe = w; p1_addr = a; p1_dout = d; p1_width = wd;
      end
   endtask

   initial begin
      //           p0r  p0w  p1r  p1w  mcc  mdin   mr   mw   bsy  gnt  cc0  cc1  din0   din1   maddr
      tbl[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 64'h0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 64'h0, 64'h0, 64'h0};
      tbl[1]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, D2,    1'b1,1'b0,1'b1,1'b0,1'b0,1'b0, 64'h0, 64'h0, A0};
      tbl[2]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, D2,    1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 64'h0, 64'h0, A0};
      tbl[3]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, D2,    1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 64'h0, 64'h0, A0};
      tbl[4]  = '{1'b0,1'b0,1'b0,1'b0,1'b1, D1,    1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, D1,    64'h0, A0};
      tbl[5]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, D3,    1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, D1,    64'h0, A0};
      tbl[6]  = '{1'b0,1'b1,1'b1,1'b0,1'b0, D3,    1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 64'h0, 64'h0, 64'h0};
      tbl[7]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, D3,    1'b0,1'b1,1'b1,1'b0,1'b0,1'b0, 64'h0, 64'h0, A0};
      tbl[8]  = '{1'b0,1'b0,1'b0,1'b0,1'b1, D2,    1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 64'h0, 64'h0, A0};
      tbl[9]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, D2,    1'b1,1'b0,1'b1,1'b1,1'b0,1'b0, 64'h0, 64'h0, A1};
      tbl[10] = '{1'b0,1'b0,1'b0,1'b0,1'b1, D3,    1'b0,1'b0,1'b0,1'b1,1'b0,1'b1, 64'h0, D3,    A1};
      tbl[11] = '{1'b0,1'b0,1'b0,1'b0,1'b0, D1,    1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 64'h0, D3,    A1};

      p0_addr = A0; p0_dout = 64'hA5A5A5A5_5A5A5A5A; p0_width = 2'd0;
      p1_addr = A1; p1_dout = 64'h0; p1_width = 2'd1;
      mem_din = 64'h0;
      idle_inputs();
      rst_n = 0;
      step();
      step();
      chk("reset_data", {p0_din, p1_din, mem_addr, mem_dout}, 256'h0);
      chk("reset_ctl", {p0_cycle_complete, p1_cycle_complete, mem_width, mem_rstrobe,
                        mem_wstrobe, grant, busy, err_overrun, err_timeout}, 256'h0);
      rst_n = 1;

      // Directed single read, then simultaneous p0 write / p1 read after a fresh reset
      for (int i = 0; i < 12; i++) begin
         if (i == 6) do_reset();
         p0_rstrobe = tbl[i].p0r; p0_wstrobe = tbl[i].p0w;
         p1_rstrobe = tbl[i].p1r; p1_wstrobe = tbl[i].p1w;
         mem_cycle_complete = tbl[i].mcc; mem_din = tbl[i].mdin;
         step();
         chk($sformatf("tbl_row%0d", i),
             {mem_rstrobe, mem_wstrobe, busy, grant, p0_cycle_complete, p1_cycle_complete,
              err_overrun, err_timeout, p0_din, p1_din, mem_addr},
             {tbl[i].mr, tbl[i].mw, tbl[i].bsy, tbl[i].gnt, tbl[i].cc0, tbl[i].cc1,
              2'b00, tbl[i].din0, tbl[i].din1, tbl[i].maddr});
      end
      idle_inputs();

      // Overrun: second p1 strobe while the first is still pending
      do_reset();
      drive_port(1, 1'b1, 1'b0, 64'h3000, 64'h0, 2'd0);
      step();
      drive_port(1, 1'b1, 1'b0, 64'h4000, 64'h0, 2'd0);
      run_mem(2, D3, 10, n_str, n_cc0, n_cc1, t_str, t_cc);
      chk("ovr_strobes", 256'(n_str), 256'd1);
      chk("ovr_cc1", 256'(n_cc1), 256'd1);
      chk("ovr_flag", {err_overrun, err_timeout}, 256'b10);
      chk("ovr_addr", mem_addr, 256'h3000);
      chk("ovr_din", p1_din, D3);

      // Completion on the timeout edge wins over the watchdog
      drive_port(0, 1'b1, 1'b0, 64'h10, 64'h0, 2'd3);
      run_mem(TO, D1, 10, n_str, n_cc0, n_cc1, t_str, t_cc);
      chk("edge_lat", 256'(t_cc - t_str), 256'(TO));
      chk("edge_cc0", 256'(n_cc0), 256'd1);
      chk("edge_noerr", err_timeout, 256'd0);
      chk("edge_din", p0_din, D1);

      // Memory never answers
      drive_port(0, 1'b1, 1'b0, 64'h20, 64'h0, 2'd0);
      run_mem(0, D2, 10, n_str, n_cc0, n_cc1, t_str, t_cc);
      chk("to_lat", 256'(t_cc - t_str), 256'(TO));
      chk("to_cc0", 256'(n_cc0), 256'd1);
      chk("to_din", p0_din, 256'h0);
      chk("to_flag", err_timeout, 256'd1);

      // Next request proceeds normally
      drive_port(1, 1'b1, 1'b0, 64'h30, 64'h0, 2'd0);
      run_mem(2, D3, 10, n_str, n_cc0, n_cc1, t_str, t_cc);
      chk("to_next_cc1", {8'(n_cc0), 8'(n_cc1)}, {8'd0, 8'd1});
      chk("to_next_lat", 256'(t_cc - t_str), 256'd2);
      chk("to_next_din", p1_din, D3);

      // Reset while in WAIT
      drive_port(0, 1'b1, 1'b0, 64'h5000, 64'h0, 2'd1);
      step();
      p0_rstrobe = 0;
      step();
      chk("rst_pre_strobe", {mem_rstrobe, busy}, 256'b11);
      step();
      rst_n = 0;
      step();
      rst_n = 1;
      chk("rst_mid_data", {p0_din, p1_din, mem_addr, mem_dout}, 256'h0);
      chk("rst_mid_ctl", {p0_cycle_complete, p1_cycle_complete, mem_width, mem_rstrobe,
                          mem_wstrobe, grant, busy, err_overrun, err_timeout}, 256'h0);
      mem_cycle_complete = 1; mem_din = D1;
      acc = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         mem_cycle_complete = 0;
         acc = acc | p0_cycle_complete | p1_cycle_complete | mem_rstrobe | mem_wstrobe | busy;
      end
      chk("rst_ignore_cc", {acc, p0_din}, 256'h0);

      // Random traffic against a transaction-level model
      do_reset();
      owner = -1; done_e = 0; mem_rem = 0; lastg = 1;
      e_addr = 0; e_dout = 0; e_w = 0; egnt = 0; eovr = 0; eto = 0; to_f = 0; rdat = 0;
      for (int p = 0; p < 2; p++) begin wt[p] = 0; os[p] = 0; edin[p] = 0; end
      for (int it = 0; it < 1500; it++) begin
         drive_port(0, 1'b0, 1'b0, p0_addr, p0_dout, p0_width);
         drive_port(1, 1'b0, 1'b0, p1_addr, p1_dout, p1_width);
         for (int p = 0; p < 2; p++) begin
            if (!os[p] && $urandom_range(0, 2) == 0) begin
               int          k;
               logic [63:0] a, d;
               logic [1:0]  wd;
               k  = $urandom_range(0, 4);
               a  = {$urandom(), $urandom()};
               d  = {$urandom(), $urandom()};
               wd = 2'($urandom_range(0, 3));
               drive_port(p, k < 2 || k == 4, k >= 2, a, d, wd);
               rq[p] = '{a, d, wd, k >= 2, cyc + 1};
               wt[p] = 1; os[p] = 1;
               if (k == 4) eovr = 1;
            end
         end
         mem_cycle_complete = (mem_rem == 1);
         if (mem_rem > 0) mem_rem--;
         mem_din = mem_cycle_complete ? rdat : {$urandom(), $urandom()};
         step();

         e_mr = 0; e_mw = 0; ecc = 2'b00;
         if (owner >= 0 && cyc == done_e) begin
            ecc[owner] = 1;
            if (!rq[owner].wr) edin[owner] = to_f ? 64'h0 : rdat;
            if (to_f) eto = 1;
            os[owner] = 0;
            owner = -1;
         end else if (owner < 0) begin
            bit c0, c1;
            int p;
            c0 = wt[0] && rq[0].cap < cyc;
            c1 = wt[1] && rq[1].cap < cyc;
            if (c0 || c1) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
               p = (c0 && c1) ? ((lastg == 1) ? 0 : 1) : (c0 ? 0 : 1);
`else
               p = c0 ? 0 : 1;
`endif
               owner = p; wt[p] = 0; lastg = p; egnt = (p == 1);
               e_mr = !rq[p].wr; e_mw = rq[p].wr;
               e_addr = rq[p].addr; e_dout = rq[p].dout; e_w = rq[p].w;
               mem_rem = $urandom_range(0, TO);
               to_f    = (mem_rem == 0);
               done_e  = to_f ? cyc + TO : cyc + mem_rem;
               rdat    = {$urandom(), $urandom()};
            end
         end
         chk("rnd_bus", {mem_rstrobe, mem_wstrobe, mem_width, mem_addr, mem_dout},
                        {e_mr, e_mw, e_w, e_addr, e_dout});
         chk("rnd_ctl", {grant, busy, p0_cycle_complete, p1_cycle_complete, err_overrun, err_timeout},
                        {egnt, owner >= 0, ecc[0], ecc[1], eovr, eto});
         chk("rnd_din", {p0_din, p1_din}, {edin[0], edin[1]});
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
